// File: rtl/resp_capture_if.sv
// rtl/resp_capture_if.sv - handshake and data bundle between the capture block and its driver
interface resp_capture_if #(
  parameter int VEC_W = 3,
  parameter int DEPTH = 8
);
  logic                   start;
  logic [VEC_W-1:0]       vec_in;
  logic                   dut_out;
  logic                   rd_en;
  logic [VEC_W:0]         rd_data;
  logic                   rd_valid;
  logic [$clog2(DEPTH):0] count;
  logic                   busy;
  logic                   done;

  modport master (
    output start, vec_in, dut_out, rd_en,
    input  rd_data, rd_valid, count, busy, done
  );

  modport slave (
    input  start, vec_in, dut_out, rd_en,
    output rd_data, rd_valid, count, busy, done
  );
endinterface

// File: rtl/resp_capture.sv
// rtl/resp_capture.sv - captures DEPTH {vec, resp} samples into a FIFO; optional MISR via RESP_MISR_EN
module resp_capture #(
  parameter int VEC_W = 3,
  parameter int DEPTH = 8
) (
  input  logic        CK,
  input  logic        reset,
  resp_capture_if.slave bus
`ifdef RESP_MISR_EN
  ,
  output logic [15:0] signature
`endif
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] LAST_SAMPLE = PTR_W'(DEPTH - 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CAPTURE = 2'd1;
  localparam logic [1:0] S_DONE    = 2'd2;

  logic [1:0]       state;
  logic [VEC_W:0]   mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] sample_cnt;
  logic [CNT_W-1:0] count_q;
  logic [VEC_W:0]   rd_data_q;
  logic             rd_valid_q;

  // start only arms from IDLE/DONE; while capturing it is ignored entirely
  logic arm;
  logic do_write;
  logic do_read;
  assign arm      = bus.start && (state != S_CAPTURE);
  assign do_write = (state == S_CAPTURE);
  // a read in the arming cycle would pop a sample that is being discarded
  assign do_read  = bus.rd_en && (count_q != '0) && !arm;

  // sequencing, pointers, occupancy and registered read port
  always_ff @(posedge CK or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      sample_cnt <= '0;
      count_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      if (arm) begin
        state      <= S_CAPTURE;
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        sample_cnt <= '0;
        count_q    <= '0;
      end else begin
        if (do_write) begin
          wr_ptr     <= wr_ptr + 1'b1;
          sample_cnt <= sample_cnt + 1'b1;
          if (sample_cnt == LAST_SAMPLE) begin
            state <= S_DONE;
          end
        end
        if (do_read) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
        case ({do_write, do_read})
          2'b10:   count_q <= count_q + 1'b1;
          2'b01:   count_q <= count_q - 1'b1;
          default: count_q <= count_q;
        endcase
      end
      rd_valid_q <= do_read;
      if (do_read) begin
        rd_data_q <= mem[rd_ptr];
      end
    end
  end

  // sample storage; contents need no reset because count gates every read
  always_ff @(posedge CK) begin
    if (do_write) begin
      mem[wr_ptr] <= {bus.vec_in, bus.dut_out};
    end
  end

`ifdef RESP_MISR_EN
  logic [15:0] sig_q;
  logic [15:0] sig_in;
  assign sig_in = 16'({bus.vec_in, bus.dut_out});

  // CRC-16/CCITT style MISR, reseeded on every arm and frozen outside CAPTURE
  always_ff @(posedge CK or posedge reset) begin
    if (reset) begin
      sig_q <= 16'hFFFF;
    end else if (arm) begin
      sig_q <= 16'hFFFF;
    end else if (do_write) begin
      sig_q <= {sig_q[14:0], 1'b0} ^ (sig_q[15] ? 16'h1021 : 16'h0000) ^ sig_in;
    end
  end

  assign signature = sig_q;
`endif

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.count    = count_q;
  assign bus.busy     = (state == S_CAPTURE);
  assign bus.done     = (state == S_DONE);
endmodule

// File: tb/tb_resp_capture.sv
// tb/tb_resp_capture.sv - scoreboard bench for resp_capture, both with and without RESP_MISR_EN
module tb_resp_capture;
  localparam int VEC_W = 3;
  localparam int DEPTH = 8;

  logic CK = 1'b0;
  logic reset = 1'b1;
  always #5 CK = ~CK;

  resp_capture_if #(.VEC_W(VEC_W), .DEPTH(DEPTH)) bus ();

`ifdef RESP_MISR_EN
  logic [15:0] signature;
  resp_capture #(.VEC_W(VEC_W), .DEPTH(DEPTH)) dut (
    .CK(CK), .reset(reset), .bus(bus), .signature(signature)
  );
`else
  resp_capture #(.VEC_W(VEC_W), .DEPTH(DEPTH)) dut (
    .CK(CK), .reset(reset), .bus(bus)
  );
`endif

  int tests_run = 0;
  int tests_failed = 0;
  logic [VEC_W:0] sb_q[$];
  logic [15:0] sig_model;

  task automatic check(input string name, input int actual, input int expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [VEC_W:0] d);
    return {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ 16'(d);
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rd_data"}, int'(bus.rd_data), 0);
    check({tag, "_rd_valid"}, int'(bus.rd_valid), 0);
    check({tag, "_count"}, int'(bus.count), 0);
    check({tag, "_busy"}, int'(bus.busy), 0);
    check({tag, "_done"}, int'(bus.done), 0);
`ifdef RESP_MISR_EN
    check({tag, "_signature"}, int'(signature), 16'hFFFF);
`endif
  endtask

  // mode 0: vec=i, resp=vec[0]; mode 1: random. rd_at: write index (1-based) carrying rd_en, 0 = none
  task automatic capture_run(input bit do_start, input bit hold_start, input int mode, input int rd_at);
    logic [VEC_W:0] exp_rd;
    logic [VEC_W:0] d;
    sig_model = 16'hFFFF;
    if (do_start) begin
      @(negedge CK);
      bus.start = 1'b1;
      @(posedge CK);
    end
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge CK);
      bus.start = hold_start;
      if (rd_at > 0 && i == rd_at) begin
        exp_rd = sb_q.pop_front();
        check("cap_rd_valid", int'(bus.rd_valid), 1);
        check("cap_rd_data", int'(bus.rd_data), int'(exp_rd));
      end
      if (mode == 0) begin
        bus.vec_in  = VEC_W'(i);
        bus.dut_out = bus.vec_in[0];
      end else begin
        bus.vec_in  = VEC_W'($urandom_range(0, (1 << VEC_W) - 1));
        bus.dut_out = 1'($urandom_range(0, 1));
      end
      d = {bus.vec_in, bus.dut_out};
      sb_q.push_back(d);
      sig_model = misr_step(sig_model, d);
      bus.rd_en = (i + 1 == rd_at);
      check("cap_busy", int'(bus.busy), 1);
      check("cap_done_low", int'(bus.done), 0);
      @(posedge CK);
    end
    @(negedge CK);
    bus.start = 1'b0;
    bus.rd_en = 1'b0;
    if (rd_at == DEPTH) begin
      exp_rd = sb_q.pop_front();
      check("cap_rd_valid_last", int'(bus.rd_valid), 1);
      check("cap_rd_data_last", int'(bus.rd_data), int'(exp_rd));
    end
    check("end_done", int'(bus.done), 1);
    check("end_busy", int'(bus.busy), 0);
    check("end_count", int'(bus.count), (rd_at > 0) ? DEPTH - 1 : DEPTH);
`ifdef RESP_MISR_EN
    check("end_signature", int'(signature), int'(sig_model));
`endif
  endtask

  task automatic drain(input int n);
    logic [VEC_W:0] exp_rd;
    for (int i = 0; i < n; i++) begin
      @(negedge CK);
      bus.rd_en = 1'b1;
      @(posedge CK);
      #1;
      bus.rd_en = 1'b0;
      if (sb_q.size() == 0) begin
        check("drain_sb_empty", 1, 0);
      end else begin
        exp_rd = sb_q.pop_front();
        check("drain_rd_valid", int'(bus.rd_valid), 1);
        check("drain_rd_data", int'(bus.rd_data), int'(exp_rd));
      end
    end
  endtask

  task automatic test_reset;
    #12;
    check_reset_outputs("reset");
    @(negedge CK);
    reset = 1'b0;
    @(negedge CK);
    check_reset_outputs("post_reset_idle");
  endtask

  task automatic test_capture;
    capture_run(1'b1, 1'b0, 0, 0);
  endtask

  task automatic test_drain;
    logic [VEC_W:0] first;
    first = sb_q[0];
    check("first_sample_literal", int'(first), 4'b0000);
    first = sb_q[1];
    check("second_sample_literal", int'(first), 4'b0011);
    drain(DEPTH);
    @(negedge CK);
    check("drain_count", int'(bus.count), 0);
    check("drain_done_hold", int'(bus.done), 1);
`ifdef RESP_MISR_EN
    check("drain_signature_hold", int'(signature), int'(sig_model));
`endif
  endtask

  task automatic test_empty_read;
    logic [VEC_W:0] prev;
    @(negedge CK);
    prev = bus.rd_data;
    bus.rd_en = 1'b1;
    @(posedge CK);
    #1;
    bus.rd_en = 1'b0;
    check("empty_rd_valid", int'(bus.rd_valid), 0);
    check("empty_rd_data", int'(bus.rd_data), int'(prev));
    check("empty_count", int'(bus.count), 0);
  endtask

  task automatic test_reset_mid;
    @(negedge CK);
    bus.start = 1'b1;
    @(posedge CK);
    for (int i = 0; i < 3; i++) begin
      @(negedge CK);
      bus.start = 1'b0;
      bus.vec_in = VEC_W'(i + 5);
      bus.dut_out = 1'b1;
      @(posedge CK);
    end
    #2;
    check("mid_count_before", int'(bus.count), 3);
    reset = 1'b1;
    #1;
    check_reset_outputs("mid_reset");
    @(negedge CK);
    reset = 1'b0;
    sb_q.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge CK);
      bus.vec_in = VEC_W'(i);
    end
    check("post_reset_no_write", int'(bus.count), 0);
    check("post_reset_busy", int'(bus.busy), 0);
    capture_run(1'b1, 1'b0, 1, 0);
    drain(DEPTH);
  endtask

  task automatic test_start_ignored;
    sb_q.delete();
    capture_run(1'b1, 1'b1, 1, 5);
    drain(3);
  endtask

  task automatic test_done_restart;
    @(negedge CK);
    check("restart_pre_count", int'(bus.count), DEPTH - 1 - 3);
    bus.start = 1'b1;
    bus.rd_en = 1'b1;
    @(posedge CK);
    #1;
    bus.start = 1'b0;
    bus.rd_en = 1'b0;
    check("restart_rd_valid", int'(bus.rd_valid), 0);
    check("restart_count", int'(bus.count), 0);
    check("restart_busy", int'(bus.busy), 1);
    sb_q.delete();
    capture_run(1'b0, 1'b0, 1, 0);
    drain(DEPTH);
    @(negedge CK);
    check("restart_final_count", int'(bus.count), 0);
  endtask

  task automatic test_final_reset;
    @(negedge CK);
    reset = 1'b1;
    #1;
    check_reset_outputs("final_reset");
    @(negedge CK);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start   = 1'b0;
    bus.vec_in  = '0;
    bus.dut_out = 1'b0;
    bus.rd_en   = 1'b0;
    test_reset;
    test_capture;
    test_drain;
    test_empty_read;
    test_reset_mid;
    test_start_ignored;
    test_done_restart;
    test_final_reset;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
